// File: rtl/dll_pkg.sv
// -----------------------------------------------------------------------------
// dll_pkg
// Shared types and defaults for the early/prompt/late DLL tracker.
//   - dll_state_e : tracker FSM states (IDLE, ACC, STEP, UPDATE)
//   - DLL_*_DEF   : default parameter values
//   - acc_width() : width of the signed early-minus-late accumulator
// No ports (package).
// -----------------------------------------------------------------------------
package dll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_STEP   = 2'd2,
        ST_UPDATE = 2'd3
    } dll_state_e;

    localparam int DLL_W_DEF           = 8;
    localparam int DLL_PHASE_W_DEF     = 16;
    localparam int DLL_N_INT_DEF       = 4;
    localparam int DLL_GAIN_SHIFT_DEF  = 2;
    localparam int DLL_MAX_STEP_DEF    = 4096;
    localparam int DLL_DEADBAND_DEF    = 2;
    localparam int DLL_SPACING_DEF     = 4096;
    localparam int DLL_LOCK_TOL_DEF    = 8;
    localparam int DLL_PROMPT_MIN_DEF  = 256;
    localparam int DLL_LOCK_CNT_DEF    = 8;
    localparam int DLL_UNLOCK_CNT_DEF  = 4;
    localparam int DLL_SEARCH_STEP_DEF = 8192;
    localparam int DLL_SEARCH_WIN_DEF  = 4;

    // One sign bit for e-l, plus growth for summing n_int samples.
    function automatic int acc_width(input int w, input int n_int);
        return w + 1 + $clog2(n_int);
    endfunction

endpackage

// File: rtl/dll_loop_filter.sv
// -----------------------------------------------------------------------------
// dll_loop_filter
// Combinational proportional loop filter: window error -> signed phase step.
// Applies deadband, arithmetic right shift and symmetric clamp.
// Ports:
//   err_i     in  ACC_W   signed integrated early-minus-late error
//   step_o    out PHASE_W signed phase step (0 inside the deadband)
//   err_abs_o out ACC_W+1 |err_i|, also used for lock qualification
// -----------------------------------------------------------------------------
module dll_loop_filter #(
    parameter int ACC_W      = 11,
    parameter int PHASE_W    = 16,
    parameter int GAIN_SHIFT = 2,
    parameter int MAX_STEP   = 4096,
    parameter int DEADBAND   = 2
) (
    input  logic signed [ACC_W-1:0]   err_i,
    output logic signed [PHASE_W-1:0] step_o,
    output logic        [ACC_W:0]     err_abs_o
);

    logic signed [ACC_W:0]   err_x;
    logic        [ACC_W:0]   err_abs;
    logic signed [ACC_W-1:0] mag;
    logic signed [63:0]      mag_x;
    logic signed [63:0]      clamped;

    // One extra bit so negating the most-negative error cannot overflow.
    assign err_x   = (ACC_W+1)'(err_i);
    assign err_abs = err_x[ACC_W] ? $unsigned(-err_x) : $unsigned(err_x);
    assign mag     = err_i >>> GAIN_SHIFT;
    assign mag_x   = 64'(mag);

    always_comb begin
        clamped = mag_x;
        if (mag_x > 64'(MAX_STEP)) begin
            clamped = 64'(MAX_STEP);
        end else if (mag_x < -64'(MAX_STEP)) begin
            clamped = -64'(MAX_STEP);
        end
    end

    assign step_o    = (32'(err_abs) <= 32'(DEADBAND)) ? '0 : PHASE_W'(clamped);
    assign err_abs_o = err_abs;

endmodule

// File: rtl/dll_tracker.sv
// -----------------------------------------------------------------------------
// dll_tracker
// Early/prompt/late DLL tracker. Integrates e-l over N_INT correlator samples,
// applies a filtered phase correction and reports lock status.
// Optional feature macro: DLL_SEARCH_EN (adds SEARCH_STEP/SEARCH_WIN; steps
// phase forward by SEARCH_STEP after SEARCH_WIN low-prompt windows while
// unlocked).
// Ports:
//   clk          in  1        system clock
//   rst_in       in  1        asynchronous active-high reset
//   corr_rdy     in  1        strobe: e/p/l_value valid (taken only when ready)
//   e/p/l_value  in  W        early/prompt/late correlator magnitudes
//   ready        out 1        high in IDLE
//   phase        out PHASE_W  prompt phase
//   phase_early  out PHASE_W  phase - SPACING (mod 2^PHASE_W)
//   phase_late   out PHASE_W  phase + SPACING (mod 2^PHASE_W)
//   phase_valid  out 1        one-cycle pulse after each phase update
//   locked       out 1        lock indicator
//   overrun      out 1        sticky: strobe arrived while busy
// -----------------------------------------------------------------------------
module dll_tracker
    import dll_pkg::*;
#(
    parameter int W          = DLL_W_DEF,
    parameter int PHASE_W    = DLL_PHASE_W_DEF,
    parameter int N_INT      = DLL_N_INT_DEF,
    parameter int GAIN_SHIFT = DLL_GAIN_SHIFT_DEF,
    parameter int MAX_STEP   = DLL_MAX_STEP_DEF,
    parameter int DEADBAND   = DLL_DEADBAND_DEF,
    parameter int SPACING    = DLL_SPACING_DEF,
    parameter int LOCK_TOL   = DLL_LOCK_TOL_DEF,
    parameter int PROMPT_MIN = DLL_PROMPT_MIN_DEF,
    parameter int LOCK_CNT   = DLL_LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = DLL_UNLOCK_CNT_DEF
`ifdef DLL_SEARCH_EN
    ,
    parameter int SEARCH_STEP = DLL_SEARCH_STEP_DEF,
    parameter int SEARCH_WIN  = DLL_SEARCH_WIN_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               corr_rdy,
    input  logic [W-1:0]       e_value,
    input  logic [W-1:0]       p_value,
    input  logic [W-1:0]       l_value,
    output logic               ready,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] phase_early,
    output logic [PHASE_W-1:0] phase_late,
    output logic               phase_valid,
    output logic               locked,
    output logic               overrun
);

    localparam int ACC_W  = acc_width(W, N_INT);
    localparam int PACC_W = W + $clog2(N_INT);
    localparam int CNT_W  = $clog2(N_INT + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    dll_state_e               state_q;
    logic [W-1:0]             e_q, p_q, l_q;
    logic signed [ACC_W-1:0]  err_acc_q, err_acc_d;
    logic [PACC_W-1:0]        p_acc_q, p_acc_d;
    logic [CNT_W-1:0]         sample_cnt_q, sample_cnt_d;
    logic signed [PHASE_W-1:0] step_q, step_d;
    logic                     good_q, good_d;
    logic [GOOD_W-1:0]        good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]         bad_cnt_q, bad_cnt_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic                     ready_q, phase_valid_q, locked_q, overrun_q;
    logic [ACC_W:0]           err_abs;
    logic signed [W:0]        diff;

    dll_loop_filter #(
        .ACC_W      (ACC_W),
        .PHASE_W    (PHASE_W),
        .GAIN_SHIFT (GAIN_SHIFT),
        .MAX_STEP   (MAX_STEP),
        .DEADBAND   (DEADBAND)
    ) u_filter (
        .err_i     (err_acc_q),
        .step_o    (step_d),
        .err_abs_o (err_abs)
    );

    // Unsigned magnitudes are zero-extended before subtracting so e-l is exact.
    assign diff         = $signed({1'b0, e_q}) - $signed({1'b0, l_q});
    assign err_acc_d    = err_acc_q + ACC_W'(diff);
    assign p_acc_d      = p_acc_q + PACC_W'(p_q);
    assign sample_cnt_d = sample_cnt_q + CNT_W'(1);
    assign good_d       = (32'(err_abs) <= 32'(LOCK_TOL)) &&
                          (32'(p_acc_q) >= 32'(PROMPT_MIN));
    assign good_cnt_d   = (good_cnt_q == GOOD_W'(LOCK_CNT)) ? good_cnt_q
                                                            : good_cnt_q + GOOD_W'(1);
    assign bad_cnt_d    = (bad_cnt_q == BAD_W'(UNLOCK_CNT)) ? bad_cnt_q
                                                            : bad_cnt_q + BAD_W'(1);

`ifdef DLL_SEARCH_EN
    localparam int SRCH_W = $clog2(SEARCH_WIN + 1);
    logic [SRCH_W-1:0] search_cnt_q, search_cnt_d;
    logic              search_fire;

    // p_acc is still held during UPDATE, so the window's prompt energy is
    // judged directly there; locked_q is the pre-update lock state.
    always_comb begin
        search_cnt_d = '0;
        search_fire  = 1'b0;
        if (!locked_q && (32'(p_acc_q) < 32'(PROMPT_MIN))) begin
            if (search_cnt_q + SRCH_W'(1) == SRCH_W'(SEARCH_WIN)) begin
                search_fire = 1'b1;
            end else begin
                search_cnt_d = search_cnt_q + SRCH_W'(1);
            end
        end
    end
`endif

    // Early > late gives a positive step and therefore an earlier phase.
    always_comb begin
        phase_d = phase_q - $unsigned(step_q);
`ifdef DLL_SEARCH_EN
        if (search_fire) begin
            phase_d = phase_q + PHASE_W'(SEARCH_STEP);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            e_q           <= '0;
            p_q           <= '0;
            l_q           <= '0;
            err_acc_q     <= '0;
            p_acc_q       <= '0;
            sample_cnt_q  <= '0;
            step_q        <= '0;
            good_q        <= 1'b0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            phase_q       <= '0;
            ready_q       <= 1'b1;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef DLL_SEARCH_EN
            search_cnt_q  <= '0;
`endif
        end else begin
            phase_valid_q <= 1'b0;
            if (corr_rdy && !ready_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (corr_rdy) begin
                        e_q     <= e_value;
                        p_q     <= p_value;
                        l_q     <= l_value;
                        state_q <= ST_ACC;
                        ready_q <= 1'b0;
                    end
                end
                ST_ACC: begin
                    err_acc_q    <= err_acc_d;
                    p_acc_q      <= p_acc_d;
                    sample_cnt_q <= sample_cnt_d;
                    if (sample_cnt_d == CNT_W'(N_INT)) begin
                        state_q <= ST_STEP;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    step_q  <= step_d;
                    good_q  <= good_d;
                    state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    phase_q       <= phase_d;
                    phase_valid_q <= 1'b1;
                    err_acc_q     <= '0;
                    p_acc_q       <= '0;
                    sample_cnt_q  <= '0;
`ifdef DLL_SEARCH_EN
                    search_cnt_q  <= search_cnt_d;
`endif
                    if (good_q) begin
                        good_cnt_q <= good_cnt_d;
                        bad_cnt_q  <= '0;
                        if (good_cnt_d == GOOD_W'(LOCK_CNT)) begin
                            locked_q <= 1'b1;
                        end
                    end else begin
                        bad_cnt_q  <= bad_cnt_d;
                        good_cnt_q <= '0;
                        if (bad_cnt_d == BAD_W'(UNLOCK_CNT)) begin
                            locked_q <= 1'b0;
                        end
                    end
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign phase       = phase_q;
    assign phase_early = phase_q - PHASE_W'(SPACING);
    assign phase_late  = phase_q + PHASE_W'(SPACING);
    assign phase_valid = phase_valid_q;
    assign locked      = locked_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_dll_tracker.sv
// -----------------------------------------------------------------------------
// tb_dll_tracker
// Self-checking bench for dll_tracker. Two instances share all inputs: one
// with default parameters, one with MAX_STEP=64 to exercise the clamp. A
// window-level reference model predicts phase, lock and overrun.
// -----------------------------------------------------------------------------
module tb_dll_tracker;

    localparam int PW = 16;

    logic          clk = 1'b0;
    bit            clk_run = 1'b0;
    logic          rst_in;
    logic          corr_rdy;
    logic [7:0]    e_value, p_value, l_value;

    logic          ready_a, phase_valid_a, locked_a, overrun_a;
    logic [PW-1:0] phase_a, phase_early_a, phase_late_a;
    logic          ready_b, phase_valid_b, locked_b, overrun_b;
    logic [PW-1:0] phase_b, phase_early_b, phase_late_b;

    int checks = 0;
    int failures = 0;

    // Reference model state (window level)
    int m_phase_a, m_phase_b, m_err, m_psum, m_n, m_good, m_bad, m_scnt;
    bit m_locked, m_overrun;

    dll_tracker u_dut_a (
        .clk(clk), .rst_in(rst_in), .corr_rdy(corr_rdy),
        .e_value(e_value), .p_value(p_value), .l_value(l_value),
        .ready(ready_a), .phase(phase_a), .phase_early(phase_early_a),
        .phase_late(phase_late_a), .phase_valid(phase_valid_a),
        .locked(locked_a), .overrun(overrun_a)
    );

    dll_tracker #(.MAX_STEP(64)) u_dut_b (
        .clk(clk), .rst_in(rst_in), .corr_rdy(corr_rdy),
        .e_value(e_value), .p_value(p_value), .l_value(l_value),
        .ready(ready_b), .phase(phase_b), .phase_early(phase_early_b),
        .phase_late(phase_late_b), .phase_valid(phase_valid_b),
        .locked(locked_b), .overrun(overrun_b)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int m);
        if (v > m) return m;
        if (v < -m) return -m;
        return v;
    endfunction

    task automatic model_reset();
        m_phase_a = 0; m_phase_b = 0; m_err = 0; m_psum = 0; m_n = 0;
        m_good = 0; m_bad = 0; m_scnt = 0; m_locked = 0; m_overrun = 0;
    endtask

    // Window outcome from the rules: floor(err/4), deadband, clamp, lock run counts.
    task automatic model_window();
        int a, mag, st_a, st_b;
        bit good, search;
        a    = (m_err < 0) ? -m_err : m_err;
        mag  = (m_err >= 0) ? m_err / 4 : -((-m_err + 3) / 4);
        st_a = (a <= 2) ? 0 : clamp(mag, 4096);
        st_b = (a <= 2) ? 0 : clamp(mag, 64);
        good = (a <= 8) && (m_psum >= 256);
        search = 1'b0;
`ifdef DLL_SEARCH_EN
        if (!m_locked && m_psum < 256) begin
            m_scnt++;
            if (m_scnt == 4) begin
                search = 1'b1;
                m_scnt = 0;
            end
        end else begin
            m_scnt = 0;
        end
`endif
        if (search) begin
            m_phase_a = (m_phase_a + 'h2000) & 'hFFFF;
            m_phase_b = (m_phase_b + 'h2000) & 'hFFFF;
        end else begin
            m_phase_a = (m_phase_a - st_a) & 'hFFFF;
            m_phase_b = (m_phase_b - st_b) & 'hFFFF;
        end
        if (good) begin
            m_good++; m_bad = 0;
            if (m_good >= 8) m_locked = 1;
        end else begin
            m_bad++; m_good = 0;
            if (m_bad >= 4) m_locked = 0;
        end
        m_err = 0; m_psum = 0; m_n = 0;
    endtask

    // Entered just after the accepting edge k of the last window sample.
    task automatic finish_window();
        chk("busy_after_last", 32'(ready_a), 0);
        @(negedge clk);
        chk("phase_hold_k1", 32'(phase_a), m_phase_a);
        chk("valid_low_k1", 32'(phase_valid_a), 0);
        @(negedge clk);
        chk("valid_low_k2", 32'(phase_valid_a), 0);
        model_window();
        @(negedge clk);
        chk("phase_a", 32'(phase_a), m_phase_a);
        chk("phase_b", 32'(phase_b), m_phase_b);
        chk("early_a", 32'(phase_early_a), (m_phase_a - 4096) & 'hFFFF);
        chk("late_a", 32'(phase_late_a), (m_phase_a + 4096) & 'hFFFF);
        chk("early_b", 32'(phase_early_b), (m_phase_b - 4096) & 'hFFFF);
        chk("late_b", 32'(phase_late_b), (m_phase_b + 4096) & 'hFFFF);
        chk("valid_pulse", 32'(phase_valid_a), 1);
        chk("valid_pulse_b", 32'(phase_valid_b), 1);
        chk("locked_a", 32'(locked_a), 32'(m_locked));
        chk("locked_b", 32'(locked_b), 32'(m_locked));
        chk("overrun_a", 32'(overrun_a), 32'(m_overrun));
        chk("overrun_b", 32'(overrun_b), 32'(m_overrun));
        @(negedge clk);
        chk("valid_drop", 32'(phase_valid_a), 0);
        chk("ready_back", 32'(ready_a), 1);
        chk("ready_back_b", 32'(ready_b), 1);
    endtask

    task automatic do_sample(input int e, input int p, input int l);
        @(negedge clk);
        corr_rdy = 1'b1; e_value = 8'(e); p_value = 8'(p); l_value = 8'(l);
        @(negedge clk);
        corr_rdy = 1'b0;
        m_err += e - l; m_psum += p; m_n++;
        if (m_n == 4) finish_window();
    endtask

    task automatic run_window(input int e, input int p, input int l);
        for (int s = 0; s < 4; s++) do_sample(e, p, l);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_in = 1'b0; corr_rdy = 1'b0;
        e_value = '0; p_value = '0; l_value = '0;
        model_reset();

        // Reset with no clock running
        #1 rst_in = 1'b1;
        #1;
        chk("rst_phase", 32'(phase_a), 32'h0000);
        chk("rst_early", 32'(phase_early_a), 32'hF000);
        chk("rst_late", 32'(phase_late_a), 32'h1000);
        chk("rst_locked", 32'(locked_a), 0);
        chk("rst_ready", 32'(ready_a), 1);
        chk("rst_valid", 32'(phase_valid_a), 0);
        chk("rst_overrun", 32'(overrun_a), 0);
        clk_run = 1'b1;
        #22;
        @(negedge clk);
        rst_in = 1'b0;

        // Basic window: err=400 -> step 100
        run_window(200, 150, 100);
        chk("basic_const", 32'(phase_a), 32'hFF9C);
        chk("basic_clamped_b", 32'(phase_b), 32'hFFC0);

        // Clamp and wrap in both directions on the MAX_STEP=64 instance
        reset_pulse();
        run_window(255, 0, 0);
        chk("clamp_neg", 32'(phase_b), 32'hFFC0);
        run_window(0, 0, 255);
        chk("clamp_wrap", 32'(phase_b), 32'h0000);
        run_window(0, 0, 255);
        chk("clamp_pos", 32'(phase_b), 32'h0040);

        // Lock after 8 good windows, unlock after 4 bad ones
        for (int w = 0; w < 8; w++) begin
            run_window(100, 100, 100);
            if (w == 6) chk("lock_pending", 32'(locked_a), 0);
        end
        chk("lock_set", 32'(locked_a), 1);
        chk("lock_phase_hold", 32'(phase_a), 32'h00FF);
        for (int w = 0; w < 4; w++) begin
            run_window(200, 100, 0);
            if (w == 2) chk("unlock_pending", 32'(locked_a), 1);
        end
        chk("unlock", 32'(locked_a), 0);

        // Randomized windows, half near the deadband/lock tolerance
        for (int w = 0; w < 24; w++) begin
            for (int s = 0; s < 4; s++) begin
                int e, l, p;
                e = int'($urandom_range(0, 255));
                p = int'($urandom_range(0, 255));
                if (w % 2 == 1) begin
                    l = e + int'($urandom_range(0, 4)) - 2;
                    if (l < 0) l = 0;
                    if (l > 255) l = 255;
                end else begin
                    l = int'($urandom_range(0, 255));
                end
                do_sample(e, p, l);
            end
        end

`ifdef DLL_SEARCH_EN
        reset_pulse();
        for (int w = 0; w < 4; w++) run_window(0, 0, 0);
        chk("search_step", 32'(phase_a), 32'h2000);
`endif

        // Strobe on two consecutive cycles: second sample dropped
        @(negedge clk);
        corr_rdy = 1'b1; e_value = 8'd50; p_value = 8'd90; l_value = 8'd10;
        @(negedge clk);
        e_value = 8'd250; p_value = 8'd250; l_value = 8'd0;
        @(negedge clk);
        corr_rdy = 1'b0;
        m_err += 40; m_psum += 90; m_n++; m_overrun = 1;
        chk("overrun_set", 32'(overrun_a), 1);
        do_sample(20, 90, 20);
        do_sample(20, 90, 20);
        do_sample(20, 90, 20);
        chk("overrun_sticky", 32'(overrun_a), 1);

        // Asynchronous reset while the FSM sits in STEP
        do_sample(180, 50, 30);
        do_sample(180, 50, 30);
        do_sample(180, 50, 30);
        @(negedge clk);
        corr_rdy = 1'b1; e_value = 8'd180; p_value = 8'd50; l_value = 8'd30;
        @(negedge clk);
        corr_rdy = 1'b0;
        @(posedge clk);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_phase", 32'(phase_a), 0);
        chk("arst_valid", 32'(phase_valid_a), 0);
        chk("arst_locked", 32'(locked_a), 0);
        chk("arst_ready", 32'(ready_a), 1);
        chk("arst_overrun", 32'(overrun_a), 0);
        chk("arst_phase_b", 32'(phase_b), 0);
        rst_in = 1'b0;
        model_reset();

        // Recovery window after reset
        run_window(120, 120, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
